instr_queue: RTL and testbench
==============================

INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; SHALL be a power of two, at least 2.
REQ-002 Parameter IW, default 9, instruction word width.
REQ-003 f_clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 f_rst_n  in  1  asynchronous, active-low reset.
REQ-005 pc_i  in  8  PC of the incoming fetched instruction.
REQ-006 instr_i  in  IW  instruction word read from instruction ROM at pc_i.
REQ-007 in_valid  in  1  pc_i/instr_i valid this cycle.
REQ-008 in_ready  out  1  queue accepts an entry this cycle.
REQ-009 flush  in  1  taken branch or start; discard all held entries.
REQ-010 halt  in  1  freeze queue: no push, no pop.
REQ-011 out_valid  out  1  head entry presented to decode.
REQ-012 out_pc  out  8  PC of head entry.
REQ-013 out_instr  out  IW  instruction of head entry.
REQ-014 out_ready  in  1  decode consumes head this cycle.
REQ-015 count  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH.

Function
REQ-016 push = in_valid & in_ready; pop = out_valid & out_ready; both SHALL be evaluated in the same cycle.
REQ-017 in_ready SHALL be (count != DEPTH) & ~halt & ~flush; no push when full, even if a pop occurs in that cycle.
REQ-018 out_valid SHALL be (count != 0) & ~halt & ~flush; out_pc/out_instr SHALL be the oldest entry, held stable while out_valid & ~out_ready.
REQ-019 Push SHALL write at wr_ptr and advance wr_ptr by 1, modulo DEPTH (wrap DEPTH-1 -> 0).
REQ-020 Pop SHALL advance rd_ptr by 1, modulo DEPTH.
REQ-021 count SHALL be +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-022 Ordering SHALL be strict FIFO; entries SHALL never duplicate or drop except by flush.
REQ-023 flush SHALL have priority over halt, push and pop: next cycle rd_ptr = wr_ptr = 0, count = 0; entry offered in the flush cycle discarded.
REQ-024 halt (without flush) SHALL hold pointers, count and storage unchanged.
REQ-025 Latency without bypass: an entry pushed in cycle N SHALL be first visible at out_valid in cycle N+1.
REQ-026 Storage contents SHALL not be reset; out_pc/out_instr are don't-care while out_valid = 0.

Reset
REQ-027 f_rst_n low SHALL immediately, without a clock, set rd_ptr = wr_ptr = 0, count = 0, out_valid = 0 and in_ready = 0.
REQ-028 After f_rst_n deasserts, in_ready SHALL be 1 (unless halt/flush) from the first rising edge; reset mid-operation SHALL discard all entries.

Configuration
REQ-029 Macro INSTR_QUEUE_BYPASS_EN defined: when count = 0, in_valid = 1, out_ready = 1, ~halt, ~flush, the incoming entry SHALL drive out_valid/out_pc/out_instr combinationally in the same cycle and SHALL NOT be stored (count stays 0).
REQ-030 When count = 0 with bypass enabled, out_valid SHALL equal in_valid & ~halt & ~flush.
REQ-031 Macro undefined: no combinational path from in_* to out_*; REQ-025 latency applies in all cases.

Verification
REQ-032 Reset, push pc 0x10/0x11/0x12/0x13 with instr 0x1A0..0x1A3, out_ready = 0 -> count = 4, in_ready = 0; then out_ready = 1 -> pops 0x10,0x11,0x12,0x13 in order.
REQ-033 Full queue (4 entries), push attempt with simultaneous pop -> push rejected, count = 3 next cycle, dropped entry never appears.
REQ-034 Count = 3, flush with in_valid = 1 (pc 0x40) -> next cycle count = 0, out_valid = 0; pc 0x40 never output.
REQ-035 Count = 2, halt = 1 for 3 cycles with in_valid and out_ready high -> count stays 2, out_valid = 0; after release head pc unchanged.
REQ-036 Stream 10 entries pc 0x00..0x09 with out_ready toggling every cycle -> pointers wrap, output sequence 0x00..0x09 exact, no loss.
REQ-037 INSTR_QUEUE_BYPASS_EN defined, empty queue, in_valid = 1 pc 0x20, out_ready = 1 -> out_valid = 1, out_pc = 0x20 same cycle, count stays 0; undefined -> out_pc = 0x20 one cycle later.

Source files
------------

// File: rtl/instr_queue.sv
// instr_queue: fetch-to-decode instruction FIFO holding PC/instruction pairs.
// Flush discards every held entry, and halt freezes the queue with no push
// and no pop. The outputs are registered-path only, so there is one cycle of
// latency from push to out_valid.
// Optional feature: define INSTR_QUEUE_BYPASS_EN to enable a same-cycle
// bypass. When the queue is empty, the incoming entry is presented directly
// to decode, and it is not stored if decode consumes it in that cycle.
module instr_queue #(
   parameter int DEPTH = 4,
   parameter int IW    = 9
) (
   input  logic                     f_clk,
   input  logic                     f_rst_n,
   input  logic [7:0]               pc_i,
   input  logic [IW-1:0]            instr_i,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     flush,
   input  logic                     halt,
   output logic                     out_valid,
   output logic [7:0]               out_pc,
   output logic [IW-1:0]            out_instr,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [7:0]    pc_mem    [DEPTH];
   logic [IW-1:0] instr_mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] occ;
   logic          alive;

   logic          empty;
   logic          full;
   logic          open_gate;
   logic          push;
   logic          pop;
   logic          bypass_fire;
   logic          do_write;
   logic          do_read;

   assign empty     = (occ == '0);
   assign full      = (occ == FULL_COUNT);
   // The queue is usable only once a clock edge has been seen after reset
   // release, and it is closed whenever halt or flush is asserted.
   assign open_gate = alive & ~halt & ~flush;

   assign in_ready  = open_gate & ~full;
   assign count     = occ;

`ifdef INSTR_QUEUE_BYPASS_EN
   // When the queue is empty, the incoming entry becomes the head seen by decode.
   always_comb begin
      out_valid = open_gate & (~empty | in_valid);
      out_pc    = pc_mem[rd_ptr];
      out_instr = instr_mem[rd_ptr];
      if (empty) begin
         out_pc    = pc_i;
         out_instr = instr_i;
      end
   end
   assign bypass_fire = empty & pop;
`else
   // The head always comes from storage, so there is no path from inputs to outputs.
   always_comb begin
      out_valid = open_gate & ~empty;
      out_pc    = pc_mem[rd_ptr];
      out_instr = instr_mem[rd_ptr];
   end
   assign bypass_fire = 1'b0;
`endif

   assign push     = in_valid & in_ready;
   assign pop      = out_valid & out_ready;
   // A bypassed entry is both accepted and consumed, so it never touches storage.
   assign do_write = push & ~bypass_fire;
   assign do_read  = pop & ~bypass_fire;

   // Entry storage is deliberately not reset; it is written at wr_ptr on accepted pushes.
   always_ff @(posedge f_clk) begin
      if (do_write) begin
         pc_mem[wr_ptr]    <= pc_i;
         instr_mem[wr_ptr] <= instr_i;
      end
   end

   // Pointers, occupancy and the post-reset alive flag. Flush overrides everything.
   always_ff @(posedge f_clk or negedge f_rst_n) begin
      if (!f_rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         occ    <= '0;
         alive  <= 1'b0;
      end else begin
         alive <= 1'b1;
         if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
         end else begin
            if (do_write) begin
               wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_read) begin
               rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_write && !do_read) begin
               occ <= occ + CW'(1);
            end else if (do_read && !do_write) begin
               occ <= occ - CW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_instr_queue.sv
// tb_instr_queue: directed scenarios plus a randomized phase for instr_queue.
// Every cycle is checked against a queue-based reference model that is
// derived from the fetch/decode handshake rules. The bench follows the
// INSTR_QUEUE_BYPASS_EN setting of the build.
module tb_instr_queue;

   localparam int DEPTH = 4;
   localparam int IW    = 9;
`ifdef INSTR_QUEUE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct packed {
      logic [7:0]    pc;
      logic [IW-1:0] instr;
   } entry_t;

   logic          f_clk;
   logic          f_rst_n;
   logic [7:0]    pc_i;
   logic [IW-1:0] instr_i;
   logic          in_valid;
   logic          in_ready;
   logic          flush;
   logic          halt;
   logic          out_valid;
   logic [7:0]    out_pc;
   logic [IW-1:0] out_instr;
   logic          out_ready;
   logic [$clog2(DEPTH):0] count;

   int checks;
   int errors;

   entry_t     mq[$];
   logic [7:0] popped[$];
   bit         m_alive;
   bit         last_push;

   instr_queue #(.DEPTH(DEPTH), .IW(IW)) dut (
      .f_clk     (f_clk),
      .f_rst_n   (f_rst_n),
      .pc_i      (pc_i),
      .instr_i   (instr_i),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .flush     (flush),
      .halt      (halt),
      .out_valid (out_valid),
      .out_pc    (out_pc),
      .out_instr (out_instr),
      .out_ready (out_ready),
      .count     (count)
   );

   // Free-running clock with a period of 10.
   initial begin
      f_clk = 1'b0;
      forever #5 f_clk = ~f_clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive the inputs, compare the outputs with the model, then advance the model.
   task automatic applyStimulus(input logic iv, input logic [7:0] pc, input logic [IW-1:0] ins,
                                input logic ordy, input logic hlt, input logic fl);
      int   sz;
      bit   e_ir;
      bit   e_ov;
      bit   do_pop;
      entry_t head;
      in_valid  = iv;
      pc_i      = pc;
      instr_i   = ins;
      out_ready = ordy;
      halt      = hlt;
      flush     = fl;
      #4;
      sz   = mq.size();
      e_ir = m_alive && (sz != DEPTH) && !hlt && !fl;
      e_ov = m_alive && !hlt && !fl && ((sz != 0) || (BYP && iv));
      head = (sz != 0) ? mq[0] : entry_t'{pc: pc, instr: ins};
      checkOutput("in_ready", 32'(in_ready), 32'(e_ir));
      checkOutput("out_valid", 32'(out_valid), 32'(e_ov));
      checkOutput("count", 32'(count), 32'(sz));
      if (e_ov) begin
         checkOutput("out_pc", 32'(out_pc), 32'(head.pc));
         checkOutput("out_instr", 32'(out_instr), 32'(head.instr));
      end
      do_pop = e_ov && ordy;
      if (do_pop) begin
         popped.push_back(out_pc);
      end
      last_push = iv && e_ir;
      @(posedge f_clk);
      if (fl) begin
         mq.delete();
      end else if (!(do_pop && sz == 0)) begin
         if (do_pop) begin
            void'(mq.pop_front());
         end
         if (last_push) begin
            mq.push_back(entry_t'{pc: pc, instr: ins});
         end
      end
      m_alive = 1'b1;
      #1;
   endtask

   // Asynchronous reset pulse, checked between clock edges, followed by the first live edge.
   task automatic doReset();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      halt      = 1'b0;
      flush     = 1'b0;
      f_rst_n   = 1'b0;
      #1;
      checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_count", 32'(count), 32'd0);
      mq.delete();
      m_alive = 1'b0;
      #2;
      f_rst_n = 1'b1;
      @(posedge f_clk);
      m_alive = 1'b1;
      #1;
      checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);
   endtask

   initial begin
      int idx;
      checks    = 0;
      errors    = 0;
      m_alive   = 1'b0;
      last_push = 1'b0;
      f_rst_n   = 1'b0;
      in_valid  = 1'b0;
      pc_i      = '0;
      instr_i   = '0;
      out_ready = 1'b0;
      halt      = 1'b0;
      flush     = 1'b0;
      @(posedge f_clk);
      #1;
      doReset();

      // Fill to capacity, then drain in order.
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h10 + i), IW'(9'h1A0 + i), 1'b0, 1'b0, 1'b0);
      checkOutput("fill_count", 32'(count), 32'd4);
      checkOutput("fill_in_ready", 32'(in_ready), 32'd0);
      popped.delete();
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'h00, '0, 1'b1, 1'b0, 1'b0);
      checkOutput("drain_n", 32'(popped.size()), 32'd4);
      for (int i = 0; i < 4 && i < popped.size(); i++) checkOutput("drain_pc", 32'(popped[i]), 32'(8'h10 + i));

      // A full queue rejects a push even when a pop happens in the same cycle.
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h50 + i), IW'(i), 1'b0, 1'b0, 1'b0);
      popped.delete();
      applyStimulus(1'b1, 8'h5F, 9'h05F, 1'b1, 1'b0, 1'b0);
      checkOutput("full_pop_count", 32'(count), 32'd3);
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'h00, '0, 1'b1, 1'b0, 1'b0);
      checkOutput("full_pop_n", 32'(popped.size()), 32'd4);
      for (int i = 0; i < 4 && i < popped.size(); i++) checkOutput("full_pop_pc", 32'(popped[i]), 32'(8'h50 + i));

      // A flush discards the stored entries and the entry offered in the same cycle.
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'h30 + i), IW'(i), 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h40, 9'h040, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 8'h00, '0, 1'b0, 1'b0, 1'b0);
      checkOutput("flush_count", 32'(count), 32'd0);
      checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
      popped.delete();
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, '0, 1'b1, 1'b0, 1'b0);
      checkOutput("flush_nothing_out", 32'(popped.size()), 32'd0);

      // Halt freezes the queue even while push and pop are requested.
      for (int i = 0; i < 2; i++) applyStimulus(1'b1, 8'(8'h60 + i), IW'(i), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'h6F, 9'h06F, 1'b1, 1'b1, 1'b0);
      checkOutput("halt_count", 32'(count), 32'd2);
      checkOutput("halt_out_valid", 32'(out_valid), 32'd0);
      applyStimulus(1'b0, 8'h00, '0, 1'b0, 1'b0, 1'b0);
      checkOutput("halt_head_pc", 32'(out_pc), 32'h60);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, '0, 1'b1, 1'b0, 1'b0);

      // Stream ten entries with out_ready toggling, which forces the pointers to wrap.
      idx = 0;
      popped.delete();
      for (int c = 0; c < 80 && popped.size() < 10; c++) begin
         applyStimulus(idx < 10, 8'(idx), IW'(9'h100 + idx), c[0], 1'b0, 1'b0);
         if (last_push) idx++;
      end
      checkOutput("stream_n", 32'(popped.size()), 32'd10);
      for (int i = 0; i < 10 && i < popped.size(); i++) checkOutput("stream_pc", 32'(popped[i]), 32'(i));

      // Latency from an empty queue: same cycle with bypass, one cycle later without it.
      applyStimulus(1'b0, 8'h00, '0, 1'b0, 1'b0, 1'b0);
      popped.delete();
      applyStimulus(1'b1, 8'h20, 9'h120, 1'b1, 1'b0, 1'b0);
`ifdef INSTR_QUEUE_BYPASS_EN
      checkOutput("bypass_taken", 32'(popped.size()), 32'd1);
      checkOutput("bypass_count", 32'(count), 32'd0);
`else
      checkOutput("nobypass_none", 32'(popped.size()), 32'd0);
      checkOutput("nobypass_count", 32'(count), 32'd1);
      checkOutput("nobypass_pc", 32'(out_pc), 32'h20);
`endif
      for (int i = 0; i < 2; i++) applyStimulus(1'b0, 8'h00, '0, 1'b1, 1'b0, 1'b0);

      // A reset in the middle of operation discards the held entries.
      for (int i = 0; i < 2; i++) applyStimulus(1'b1, 8'(8'h70 + i), IW'(i), 1'b0, 1'b0, 1'b0);
      doReset();
      checkOutput("midrst_count", 32'(count), 32'd0);

      // Randomized traffic, with occasional halt and flush, checked against the model.
      for (int c = 0; c < 400; c++) begin
         applyStimulus(1'($urandom_range(0, 3) != 0), 8'($urandom), IW'($urandom),
                       1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 9) == 0),
                       1'($urandom_range(0, 19) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
